// File: rtl/agu_pkg.sv
// Shared definitions for the burst address generation unit.
// Holds the ADDR1/ADDR2 mux encodings, the IDLE/BURST state encoding
// and the sign-extend helper used by the effective-address datapath.
package agu_pkg;

  // ADDR1 mux select
  localparam logic ADDR1_PC    = 1'b0;
  localparam logic ADDR1_BASER = 1'b1;

  // ADDR2 mux select
  localparam logic [1:0] ADDR2_ZERO = 2'd0;
  localparam logic [1:0] ADDR2_OFFA = 2'd1;
  localparam logic [1:0] ADDR2_OFFB = 2'd2;
  localparam logic [1:0] ADDR2_OFFC = 2'd3;

  // Burst sequencer state
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_BURST = 1'b1;

  localparam int unsigned SEXT_MAX_W = 64;

  // Sign-extend the low from_w bits of val to SEXT_MAX_W bits.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] val,
                                                 input int unsigned from_w);
    logic [SEXT_MAX_W-1:0] hi_mask;
    logic [SEXT_MAX_W-1:0] sign_shift;
    hi_mask    = ~SEXT_MAX_W'(0) << from_w;
    sign_shift = val >> (from_w - 32'd1);
    if (sign_shift[0]) begin
      return val | hi_mask;
    end
    return val & ~hi_mask;
  endfunction

endpackage

// File: rtl/agu_ea_comb.sv
// Combinational effective-address datapath: ADDR1 mux, sign-extended
// offset select, optional left shift and modulo-2^WIDTH add.
// Ports:
//   addr1_sel  - 0 = pc, 1 = sr1
//   addr2_sel  - zero / offset A / offset B / offset C
//   lshft      - shift the extended offset left by one
//   ir_off     - low OFF_C_W bits of the instruction register
//   pc, sr1    - ADDR1 candidates
//   ea         - effective address
//   carry      - address ran past 2^WIDTH-1 (upward wrap only)
module agu_ea_comb
  import agu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned OFF_A_W = 6,
  parameter int unsigned OFF_B_W = 9,
  parameter int unsigned OFF_C_W = 11
) (
  input  logic               addr1_sel,
  input  logic [1:0]         addr2_sel,
  input  logic               lshft,
  input  logic [OFF_C_W-1:0] ir_off,
  input  logic [WIDTH-1:0]   pc,
  input  logic [WIDTH-1:0]   sr1,
  output logic [WIDTH-1:0]   ea,
  output logic               carry
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] ext;
  logic [WIDTH-1:0] addr2;
  logic [SUM_W-1:0] sum;
  logic             neg;

  // Mux, extend, shift and add
  always_comb begin
    ext   = '0;
    addr1 = (addr1_sel == ADDR1_BASER) ? sr1 : pc;
    case (addr2_sel)
      ADDR2_ZERO: ext = '0;
      ADDR2_OFFA: ext = WIDTH'(sext(SEXT_MAX_W'(ir_off[OFF_A_W-1:0]), OFF_A_W));
      ADDR2_OFFB: ext = WIDTH'(sext(SEXT_MAX_W'(ir_off[OFF_B_W-1:0]), OFF_B_W));
      ADDR2_OFFC: ext = WIDTH'(sext(SEXT_MAX_W'(ir_off), OFF_C_W));
    endcase
    neg   = ext[WIDTH-1];
    addr2 = lshft ? {ext[WIDTH-2:0], 1'b0} : ext;
    sum   = SUM_W'(addr1) + SUM_W'(addr2);
    ea    = sum[WIDTH-1:0];
    // A negative offset always produces a raw carry unless it borrows;
    // only a genuine run past the top of memory counts as a wrap.
    carry = sum[WIDTH] & ~neg;
  end

endmodule

// File: rtl/agu_burst.sv
// Pipelined address generation unit with multi-beat burst expansion.
// Computes ADDR1 + (shifted) sign-extended IR offset, registers it behind
// a valid/ready handshake and steps it by 1 (byte) or 2 (word) per beat.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   IN_VALID/IN_READY   - request handshake (IN_READY is combinational)
//   ADDR1_SEL, ADDR2_SEL, LSHFT, IR, PC, SR1 - address operands
//   BEATS               - burst length minus one
//   OUT_VALID/OUT_READY - beat handshake
//   OUT_ADDR, OUT_BEAT, OUT_LAST, OUT_FAULT, OUT_WRAP - beat payload
// Build option: define AGU_ALIGN_CHECK_EN to turn misaligned word requests
// into a single faulting beat; otherwise OUT_FAULT is tied low.
module agu_burst
  import agu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned OFF_A_W = 6,
  parameter int unsigned OFF_B_W = 9,
  parameter int unsigned OFF_C_W = 11,
  parameter int unsigned BEAT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              ADDR1_SEL,
  input  logic [1:0]        ADDR2_SEL,
  input  logic              LSHFT,
  input  logic [WIDTH-1:0]  IR,
  input  logic [WIDTH-1:0]  PC,
  input  logic [WIDTH-1:0]  SR1,
  input  logic [BEAT_W-1:0] BEATS,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WIDTH-1:0]  OUT_ADDR,
  output logic [BEAT_W-1:0] OUT_BEAT,
  output logic              OUT_LAST,
  output logic              OUT_FAULT,
  output logic              OUT_WRAP
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0]  ea;
  logic              ea_carry;
  logic              unused_ir;

  state_t            state_q;
  state_t            state_d;
  logic              word_q;
  logic              word_d;
  logic [BEAT_W-1:0] remain_q;
  logic [BEAT_W-1:0] remain_d;
  logic              valid_d;
  logic [WIDTH-1:0]  addr_d;
  logic [BEAT_W-1:0] beat_d;
  logic              last_d;
  logic              fault_d;
  logic              wrap_d;

  logic              accept_c;
  logic              consume_c;
  logic              fault_c;
  logic [BEAT_W-1:0] beats_eff_c;
  logic [SUM_W-1:0]  step_c;

  agu_ea_comb #(
    .WIDTH   (WIDTH),
    .OFF_A_W (OFF_A_W),
    .OFF_B_W (OFF_B_W),
    .OFF_C_W (OFF_C_W)
  ) u_ea (
    .addr1_sel (ADDR1_SEL),
    .addr2_sel (ADDR2_SEL),
    .lshft     (LSHFT),
    .ir_off    (IR[OFF_C_W-1:0]),
    .pc        (PC),
    .sr1       (SR1),
    .ea        (ea),
    .carry     (ea_carry)
  );

  // Opcode bits above the widest offset field are not part of the address
  assign unused_ir = ^IR[WIDTH-1:OFF_C_W];

  // Free to accept when nothing is outstanding or the last beat leaves now
  assign IN_READY  = !OUT_VALID || (OUT_READY && OUT_LAST);
  assign accept_c  = IN_VALID && IN_READY;
  assign consume_c = OUT_VALID && OUT_READY;

`ifdef AGU_ALIGN_CHECK_EN
  assign fault_c = LSHFT & ea[0];
`else
  assign fault_c = 1'b0;
`endif

  // A faulting request collapses to one beat regardless of BEATS
  assign beats_eff_c = fault_c ? '0 : BEATS;
  assign step_c      = SUM_W'(OUT_ADDR) + (word_q ? SUM_W'(2) : SUM_W'(1));

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    remain_d = remain_q;
    valid_d  = OUT_VALID;
    addr_d   = OUT_ADDR;
    beat_d   = OUT_BEAT;
    last_d   = OUT_LAST;
    fault_d  = OUT_FAULT;
    wrap_d   = OUT_WRAP;
    if (accept_c) begin
      valid_d  = 1'b1;
      addr_d   = ea;
      beat_d   = '0;
      wrap_d   = ea_carry;
      fault_d  = fault_c;
      word_d   = LSHFT;
      remain_d = beats_eff_c;
      last_d   = (beats_eff_c == '0);
      state_d  = (beats_eff_c == '0) ? ST_IDLE : ST_BURST;
    end else if (consume_c) begin
      if (state_q == ST_BURST) begin
        addr_d   = step_c[WIDTH-1:0];
        wrap_d   = step_c[WIDTH];
        beat_d   = OUT_BEAT + BEAT_W'(1);
        remain_d = remain_q - BEAT_W'(1);
        last_d   = (remain_q == BEAT_W'(1));
        state_d  = (remain_q == BEAT_W'(1)) ? ST_IDLE : ST_BURST;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Beat payload and burst bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= 1'b0;
      remain_q  <= '0;
      OUT_VALID <= 1'b0;
      OUT_ADDR  <= '0;
      OUT_BEAT  <= '0;
      OUT_LAST  <= 1'b0;
      OUT_FAULT <= 1'b0;
      OUT_WRAP  <= 1'b0;
    end else begin
      word_q    <= word_d;
      remain_q  <= remain_d;
      OUT_VALID <= valid_d;
      OUT_ADDR  <= addr_d;
      OUT_BEAT  <= beat_d;
      OUT_LAST  <= last_d;
      OUT_FAULT <= fault_d;
      OUT_WRAP  <= wrap_d;
    end
  end

endmodule

// File: doc/agu_burst.md
Name: agu_burst

Overview:
Parametrised, pipelined successor to the LC-3b address adder.
- Computes the effective address ADDR1 + (optionally shifted) sign-extended IR offset.
- Registers the result behind a valid/ready handshake.
- Expands one request into a multi-beat burst of sequential addresses, stepping by byte or word.
- Sits between decode/microsequencer and the memory interface; serves LDB/LDW/STB/STW and multi-word transfers.

Parameters:
- WIDTH, 16, address/data width; must be >= 12.
- OFF_A_W, 6, width of offset field A, IR[OFF_A_W-1:0].
- OFF_B_W, 9, width of offset field B, IR[OFF_B_W-1:0].
- OFF_C_W, 11, width of offset field C, IR[OFF_C_W-1:0].
- BEAT_W, 3, width of the beat counter; a burst has at most 2^BEAT_W beats.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- IN_VALID, input, 1, request valid.
- IN_READY, output, 1, request accepted when IN_VALID && IN_READY.
- ADDR1_SEL, input, 1, 0 = PC, 1 = SR1.
- ADDR2_SEL, input, 2, 0 = zero, 1 = SEXT(offset A), 2 = SEXT(offset B), 3 = SEXT(offset C).
- LSHFT, input, 1, shift offset left by 1; also selects word stride.
- IR, input, WIDTH, instruction register.
- PC, input, WIDTH, program counter.
- SR1, input, WIDTH, base register value.
- BEATS, input, BEAT_W, burst length minus one.
- OUT_VALID, output, 1, address beat valid.
- OUT_READY, input, 1, consumer accepts the beat.
- OUT_ADDR, output, WIDTH, current beat address.
- OUT_BEAT, output, BEAT_W, beat index, 0-based.
- OUT_LAST, output, 1, final beat of the request.
- OUT_FAULT, output, 1, misaligned word access.
- OUT_WRAP, output, 1, this beat's address wrapped past 2^WIDTH-1.

Behaviour:
- Effective-address arithmetic (ea):
  - ea = addr1 + addr2, modulo 2^WIDTH; carry discarded.
  - Offsets are sign-extended from their top field bit to WIDTH.
  - Shift is applied after extension.
- Stride: 2 if LSHFT=1 (word), else 1 (byte). Captured at accept.
- Handshake:
  - IN_READY = !OUT_VALID || (OUT_READY && OUT_LAST), combinational.
  - This gives back-to-back single-beat throughput of 1 per cycle.
- Latency: accept in cycle N -> OUT_VALID=1 with OUT_ADDR=ea, OUT_BEAT=0 in cycle N+1.
- States:
  - IDLE (no beat outstanding, or the last beat is outstanding).
  - BURST (non-last beat outstanding).
- Transitions:
  - Accept with BEATS=0 -> IDLE with OUT_LAST=1.
  - Accept with BEATS>0 -> BURST, remaining count = BEATS.
  - In BURST, on OUT_VALID && OUT_READY: OUT_ADDR += stride, OUT_BEAT++, remaining count--.
  - When the remaining count reaches 0, assert OUT_LAST and return to IDLE.
- Hold: while OUT_VALID && !OUT_READY, all OUT_* stay stable; no request is accepted.
- Last beat consumed, same cycle:
  - With IN_VALID: new request loads next cycle, with no bubble.
  - Without IN_VALID: OUT_VALID drops next cycle.
- Wrap: OUT_WRAP=1 on any beat whose address came from a carry-out of WIDTH bits, including the ea computation itself. The address wraps to low memory and the burst continues.
- Fault: see the optional feature below.
- Reset:
  - OUT_VALID=0, OUT_ADDR=0, OUT_BEAT=0, OUT_LAST=0, OUT_FAULT=0, OUT_WRAP=0, state IDLE.
  - IN_READY=1 once reset deasserts.
  - Reset mid-burst discards remaining beats with no further OUT_VALID.
  - A request presented during rst is not accepted.

Optional Feature:
AGU_ALIGN_CHECK_EN
- Defined: a word request (LSHFT=1) with ea[0]=1 is emitted as a single beat carrying ea, with OUT_FAULT=1 and OUT_LAST=1. BEATS is ignored and the block returns to IDLE after the handshake. Byte requests never fault.
- Undefined: OUT_FAULT is tied 0 and misaligned word bursts run normally at stride 2.

Decomposition:
- Shared package agu_pkg holds:
  - ADDR1_PC / ADDR1_BASER.
  - ADDR2_ZERO / ADDR2_OFFA / ADDR2_OFFB / ADDR2_OFFC encodings.
  - The IDLE/BURST state typedef.
  - The sign-extend helper function.
- One natural sub-module: agu_ea_comb, the combinational mux/sign-extend/shift/add. It returns ea and a carry flag, which is reused by the burst sequencer.

Test Plan:
- Single beat, negative offset: PC=0x3000, ADDR1_SEL=0, ADDR2_SEL=2, IR[8:0]=0x1FF, LSHFT=1, BEATS=0 -> one beat 0x2FFE, LAST=1, WRAP=0, one cycle after accept.
- Word burst: SR1=0x1000, ADDR2_SEL=1, IR[5:0]=0x02, LSHFT=1, BEATS=3 -> beats 0x1004, 0x1006, 0x1008, 0x100A with OUT_BEAT 0..3 and LAST only on 0x100A. IN_READY=0 until the last handshake.
- Backpressure: during the word burst above, hold OUT_READY=0 for 3 cycles on beat 1 -> OUT_ADDR stays 0x1006, no skipped or duplicated beats. Then assert back-to-back single-beat requests -> one result per cycle, no bubble.
- Wrap: SR1=0xFFFE, ADDR2_SEL=0, LSHFT=1, BEATS=1 -> 0xFFFE (WRAP=0), then 0x0000 (WRAP=1, LAST=1).
- Fault: SR1=0x1001, ADDR2_SEL=0, LSHFT=1, BEATS=3 -> with AGU_ALIGN_CHECK_EN, one beat 0x1001 with FAULT=1, LAST=1. Without it, 0x1001, 0x1003, 0x1005, 0x1007 with FAULT=0. Byte variant (LSHFT=0) -> 0x1001..0x1004, no fault.
- Reset mid-burst: assert rst during beat 1 of a 4-beat burst -> next cycle OUT_VALID=0 and all outputs zero, IN_READY=1 after release, next request starts at OUT_BEAT=0.
